// File: rtl/date_pkg.sv
// rtl/date_pkg.sv - shared types, month constants and day-of-year table
//
// Purpose: common definitions for the date_set_ctrl slice.
//   state_t      : one-hot edit FSM state vector
//   ST_*         : state encodings (RUN, SET_MM, SET_DD)
//   MM_* / DD_*  : month and day constants used by the rollover/clamp logic
//   days_before  : cumulative days before a month, non-leap year
package date_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RUN    = 3'b001;
  localparam state_t ST_SET_MM = 3'b010;
  localparam state_t ST_SET_DD = 3'b100;

  localparam logic [3:0] MM_JAN = 4'd1;
  localparam logic [3:0] MM_FEB = 4'd2;
  localparam logic [3:0] MM_DEC = 4'd12;

  localparam logic [4:0] DD_FIRST    = 5'd1;
  localparam logic [4:0] DD_FEB      = 5'd28;
  localparam logic [4:0] DD_FEB_LEAP = 5'd29;

  // Non-leap table; the leap day is added by the caller for months after Feb.
  function automatic logic [8:0] days_before(input logic [3:0] mm);
    logic [8:0] d;
    case (mm)
      4'd1:    d = 9'd0;
      4'd2:    d = 9'd31;
      4'd3:    d = 9'd59;
      4'd4:    d = 9'd90;
      4'd5:    d = 9'd120;
      4'd6:    d = 9'd151;
      4'd7:    d = 9'd181;
      4'd8:    d = 9'd212;
      4'd9:    d = 9'd243;
      4'd10:   d = 9'd273;
      4'd11:   d = 9'd304;
      4'd12:   d = 9'd334;
      default: d = 9'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/date_set_ctrl_month_len.sv
// rtl/date_set_ctrl_month_len.sv - combinational month length lookup
//
// Purpose: number of days in a month.
// Ports:
//   mm_i      month 1..12
//   leap_i    effective leap flag (Feb = 29 when set)
//   length_o  days in month, 28..31
module month_len
  import date_pkg::*;
(
  input  logic [3:0] mm_i,
  input  logic       leap_i,
  output logic [4:0] length_o
);

  always_comb begin
    case (mm_i)
      4'd2:                      length_o = leap_i ? DD_FEB_LEAP : DD_FEB;
      4'd4, 4'd6, 4'd9, 4'd11:   length_o = 5'd30;
      default:                   length_o = 5'd31;
    endcase
  end

endmodule

// File: rtl/date_set_ctrl.sv
// rtl/date_set_ctrl.sv - calendar month/day register with key-driven edit FSM
//
// Purpose: keeps month/day, advances on tick in RUN, lets keys set month and
// day in SET_MM / SET_DD, and reports day-of-year combinationally.
// Build option: DATE_SET_LEAP_EN - when defined the leap input is honoured;
// otherwise February is always 28 days and leap is ignored.
// Ports:
//   clock_i       system clock, rising edge
//   reset_i       synchronous active-high reset
//   tick_i        one-cycle day-advance pulse
//   key_mode_i    one-cycle pulse, RUN -> SET_MM -> SET_DD -> RUN
//   key_inc_i     one-cycle pulse, increments field under edit
//   leap_i        level, 1 = leap year
//   mm_o          month 1..12
//   dd_o          day 1..31
//   doy_o         day of year 1..366
//   edit_mm_o     high in SET_MM
//   edit_dd_o     high in SET_DD
//   year_wrap_o   one-cycle pulse on tick-driven Dec 31 -> Jan 1
module date_set_ctrl
  import date_pkg::*;
#(
  parameter int START_MM = 1,
  parameter int START_DD = 1
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       key_mode_i,
  input  logic       key_inc_i,
  input  logic       leap_i,
  output logic [3:0] mm_o,
  output logic [4:0] dd_o,
  output logic [8:0] doy_o,
  output logic       edit_mm_o,
  output logic       edit_dd_o,
  output logic       year_wrap_o
);

  localparam logic [3:0] START_MM_L = 4'(START_MM);
  localparam logic [4:0] START_DD_L = 5'(START_DD);

  state_t     state_q, state_d;
  logic [3:0] mm_q, mm_d;
  logic [4:0] dd_q, dd_d;
  logic       wrap_q, wrap_d;

  logic       leap_eff;
  logic [3:0] mm_next;
  logic [3:0] len_mm;
  logic [4:0] len;

`ifdef DATE_SET_LEAP_EN
  assign leap_eff = leap_i;
`else
  logic unused_leap;
  assign unused_leap = leap_i;
  assign leap_eff    = 1'b0;
`endif

  assign mm_next = (mm_q == MM_DEC) ? MM_JAN : mm_q + 4'd1;

  // Single length lookup: while editing the month the clamp needs the length
  // of the month being stepped to; everywhere else the current month is used.
  assign len_mm = (state_q == ST_SET_MM) ? mm_next : mm_q;

  month_len u_month_len (
    .mm_i     (len_mm),
    .leap_i   (leap_eff),
    .length_o (len)
  );

  always_comb begin
    state_d = state_q;
    mm_d    = mm_q;
    dd_d    = dd_q;
    wrap_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (tick_i) begin
          // >= also covers a Feb 29 whose leap flag drops on the same tick.
          if (dd_q >= len) begin
            dd_d = DD_FIRST;
            if (mm_q == MM_DEC) begin
              mm_d   = MM_JAN;
              wrap_d = 1'b1;
            end else begin
              mm_d = mm_q + 4'd1;
            end
          end else begin
            dd_d = dd_q + 5'd1;
          end
        end
        if (key_mode_i) state_d = ST_SET_MM;
      end
      ST_SET_MM: begin
        if (key_mode_i) begin
          state_d = ST_SET_DD;
        end else if (key_inc_i) begin
          mm_d = mm_next;
          dd_d = (dd_q > len) ? len : dd_q;
        end
      end
      ST_SET_DD: begin
        if (key_mode_i) begin
          state_d = ST_RUN;
        end else if (key_inc_i) begin
          dd_d = (dd_q >= len) ? DD_FIRST : dd_q + 5'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
    // Leap flag withdrawn while sitting on Feb 29: pull back to Feb 28.
    if (!leap_eff && mm_d == MM_FEB && dd_d == DD_FEB_LEAP) dd_d = DD_FEB;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_RUN;
      mm_q    <= START_MM_L;
      dd_q    <= START_DD_L;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mm_q    <= mm_d;
      dd_q    <= dd_d;
      wrap_q  <= wrap_d;
    end
  end

  assign mm_o        = mm_q;
  assign dd_o        = dd_q;
  assign doy_o       = days_before(mm_q) + {4'd0, dd_q}
                     + {8'd0, (leap_eff && (mm_q > MM_FEB))};
  assign edit_mm_o   = (state_q == ST_SET_MM);
  assign edit_dd_o   = (state_q == ST_SET_DD);
  assign year_wrap_o = wrap_q;

endmodule

// File: tb/tb_date_set_ctrl.sv
// tb/tb_date_set_ctrl.sv - self-checking bench for date_set_ctrl
module tb_date_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       kmode = 1'b0;
  logic       kinc = 1'b0;
  logic       leap = 1'b0;
  logic [3:0] mm;
  logic [4:0] dd;
  logic [8:0] doy;
  logic       edit_mm;
  logic       edit_dd;
  logic       yw;

  int checks = 0;
  int failures = 0;

  // Calendar model: month, day, mode (0 run, 1 set month, 2 set day).
  int m_mm = 1;
  int m_dd = 1;
  int m_mode = 0;
  int m_wrap = 0;
  bit armed = 1'b0;

  date_set_ctrl dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .tick_i      (tick),
    .key_mode_i  (kmode),
    .key_inc_i   (kinc),
    .leap_i      (leap),
    .mm_o        (mm),
    .dd_o        (dd),
    .doy_o       (doy),
    .edit_mm_o   (edit_mm),
    .edit_dd_o   (edit_dd),
    .year_wrap_o (yw)
  );

  always #5 clk = ~clk;

  function automatic bit eff_leap(input bit l);
`ifdef DATE_SET_LEAP_EN
    return l;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int mlen(input int m, input bit lp);
    if (m == 2) return lp ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic int mdoy(input int m, input int d, input bit lp);
    int s;
    s = d;
    for (int i = 1; i < m; i++) s += mlen(i, lp);
    return s;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit lp;
    lp = eff_leap(leap);
    if (rst) begin
      m_mode = 0; m_mm = 1; m_dd = 1; m_wrap = 0;
      armed = 1'b1;
    end else begin
      m_wrap = 0;
      if (m_mode == 0) begin
        if (tick) begin
          if (m_dd >= mlen(m_mm, lp)) begin
            m_dd = 1;
            if (m_mm == 12) begin m_mm = 1; m_wrap = 1; end
            else m_mm = m_mm + 1;
          end else m_dd = m_dd + 1;
        end
        if (kmode) m_mode = 1;
      end else if (m_mode == 1) begin
        if (kmode) m_mode = 2;
        else if (kinc) begin
          m_mm = (m_mm % 12) + 1;
          if (m_dd > mlen(m_mm, lp)) m_dd = mlen(m_mm, lp);
        end
      end else begin
        if (kmode) m_mode = 0;
        else if (kinc) m_dd = (m_dd >= mlen(m_mm, lp)) ? 1 : m_dd + 1;
      end
      if (m_mm == 2 && m_dd > mlen(2, lp)) m_dd = mlen(2, lp);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("cyc_mm", int'(mm), m_mm);
      chk("cyc_dd", int'(dd), m_dd);
      chk("cyc_doy", int'(doy), mdoy(m_mm, m_dd, eff_leap(leap)));
      chk("cyc_edit_mm", int'(edit_mm), int'(m_mode == 1));
      chk("cyc_edit_dd", int'(edit_dd), int'(m_mode == 2));
      chk("cyc_wrap", int'(yw), m_wrap);
    end
  end

  task automatic cyc(input bit t, input bit m, input bit i);
    tick = t; kmode = m; kinc = i;
    @(posedge clk);
    #1;
    tick = 0; kmode = 0; kinc = 0;
  endtask

  task automatic set_date(input int m, input int d);
    cyc(0, 1, 0);
    for (int k = 0; k < 12 && m_mm != m; k++) cyc(0, 0, 1);
    cyc(0, 1, 0);
    for (int k = 0; k < 31 && m_dd != d; k++) cyc(0, 0, 1);
    cyc(0, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    chk("rst_mm", int'(mm), 1);
    chk("rst_dd", int'(dd), 1);
    chk("rst_doy", int'(doy), 1);
    chk("rst_edit", int'({edit_mm, edit_dd}), 0);
    chk("rst_wrap", int'(yw), 0);

    repeat (31) cyc(1, 0, 0);
    chk("t31_mm", int'(mm), 2);
    chk("t31_dd", int'(dd), 1);
    chk("t31_doy", int'(doy), 32);

    leap = 1;
    set_date(2, 28);
    cyc(1, 0, 0);
`ifdef DATE_SET_LEAP_EN
    chk("leap_mm", int'(mm), 2);
    chk("leap_dd", int'(dd), 29);
`else
    chk("leap_mm", int'(mm), 3);
    chk("leap_dd", int'(dd), 1);
`endif
    chk("leap_doy", int'(doy), 60);

    leap = 0;
    set_date(2, 28);
    cyc(1, 0, 0);
    chk("noleap_mm", int'(mm), 3);
    chk("noleap_dd", int'(dd), 1);
    chk("noleap_doy", int'(doy), 60);

`ifdef DATE_SET_LEAP_EN
    leap = 1;
    set_date(2, 29);
    chk("feb29_dd", int'(dd), 29);
    leap = 0;
    @(posedge clk);
    #1;
    chk("leapfall_dd", int'(dd), 28);
`endif

    set_date(12, 31);
    chk("dec31_doy", int'(doy), 365);
    cyc(1, 0, 0);
    chk("ny_wrap", int'(yw), 1);
    chk("ny_mm", int'(mm), 1);
    chk("ny_dd", int'(dd), 1);
    chk("ny_doy", int'(doy), 1);
    cyc(0, 0, 0);
    chk("ny_wrap_off", int'(yw), 0);

    set_date(1, 31);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    chk("clamp_mm", int'(mm), 2);
    chk("clamp_dd", int'(dd), 28);
    chk("clamp_edit_mm", int'(edit_mm), 1);
    repeat (10) cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("editwrap_mm", int'(mm), 1);
    chk("editwrap_yw", int'(yw), 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);

    set_date(4, 30);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("setdd_edit_dd", int'(edit_dd), 1);
    cyc(0, 0, 1);
    chk("setdd_wrap_dd", int'(dd), 1);
    cyc(1, 0, 0);
    chk("setdd_tick_dd", int'(dd), 1);
    chk("setdd_tick_mm", int'(mm), 4);
    cyc(0, 1, 0);

    cyc(1, 0, 1);
    chk("run_inc_dd", int'(dd), 2);
    cyc(1, 1, 0);
    chk("tickmode_dd", int'(dd), 3);
    chk("tickmode_edit", int'(edit_mm), 1);
    cyc(0, 1, 0);
    cyc(0, 1, 0);

    cyc(0, 1, 1);
    chk("modeinc_edit", int'(edit_mm), 1);
    chk("modeinc_mm", int'(mm), 4);
    cyc(0, 1, 0);
    chk("modeinc_setdd", int'(edit_dd), 1);
    rst = 1;
    cyc(0, 0, 1);
    rst = 0;
    chk("rst2_mm", int'(mm), 1);
    chk("rst2_dd", int'(dd), 1);
    chk("rst2_edit", int'({edit_mm, edit_dd}), 0);
    chk("rst2_doy", int'(doy), 1);

    cyc(0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
